// File: rtl/cache_defs.sv
// ---------------------------------------------------------------------------
// cache_defs
//   Constants and types shared by the data-cache write-back path.
//   - VICTIM_WB_DEPTH   : default number of buffered dirty lines
//   - LINE_ADDR_WIDTH   : line address width (byte address, offset stripped)
//   - DCACHE_LINE_WIDTH : data bits per cache line
//   - wb_state_t        : drain FSM states
//   - wb_entry_t        : one write-back buffer entry at default widths
// ---------------------------------------------------------------------------
package cache_defs;

    localparam int VICTIM_WB_DEPTH   = 4;
    localparam int LINE_ADDR_WIDTH   = 28;
    localparam int DCACHE_LINE_WIDTH = 128;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_SEND = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic                         valid;
        logic [LINE_ADDR_WIDTH-1:0]   addr;
        logic [DCACHE_LINE_WIDTH-1:0] data;
    } wb_entry_t;

endpackage : cache_defs

// File: rtl/wb_addr_match.sv
// ---------------------------------------------------------------------------
// wb_addr_match
//   Comparator array over the write-back buffer entries. Compares a probe
//   address against every valid entry and returns the youngest match only.
//   Ports:
//     valid_i      : per-entry valid (callers may mask entries out)
//     addr_i       : per-entry line address
//     probe_i      : address to look for
//     tail_i       : buffer tail pointer (next write slot)
//     match_yf_o   : one-hot, bit k set = k-th youngest entry (0 = tail-1)
//     match_phys_o : the same single match, indexed by physical slot
// ---------------------------------------------------------------------------
module wb_addr_match
    import cache_defs::*;
#(
    parameter int DEPTH = VICTIM_WB_DEPTH,
    parameter int AW    = LINE_ADDR_WIDTH
) (
    input  logic [DEPTH-1:0]          valid_i,
    input  logic [DEPTH-1:0][AW-1:0]  addr_i,
    input  logic [AW-1:0]             probe_i,
    input  logic [$clog2(DEPTH)-1:0]  tail_i,
    output logic [DEPTH-1:0]          match_yf_o,
    output logic [DEPTH-1:0]          match_phys_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] raw_match;
    logic [DEPTH-1:0] yf_match;
    logic             found;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign raw_match[gi] = valid_i[gi] && (addr_i[gi] == probe_i);
        end

        // Reorder so bit 0 is the slot just behind the tail (youngest).
        // DEPTH is a power of two, so the subtraction wraps naturally.
        for (gi = 0; gi < DEPTH; gi++) begin : g_yf
            logic [PW-1:0] slot;
            assign slot         = tail_i - PW'(gi + 1);
            assign yf_match[gi] = raw_match[slot];
        end
    endgenerate

    // Keep only the youngest match.
    always_comb begin
        match_yf_o = '0;
        found      = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (yf_match[k] && !found) begin
                match_yf_o[k] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Map the chosen match back to its physical slot.
    always_comb begin
        match_phys_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_phys_o[tail_i - PW'(k + 1)] = match_yf_o[k];
        end
    end

endmodule : wb_addr_match

// File: rtl/victim_wb_buffer.sv
// ---------------------------------------------------------------------------
// victim_wb_buffer
//   Write-back buffer behind the data-cache victim cache. Clean evictions
//   are dropped, dirty evictions are queued (or coalesced into a pending
//   entry for the same line) and drained to memory over a req/ack
//   handshake. Pending data is forwarded to the refill path on lookup.
//   Ports:
//     clk, rst            : clock, asynchronous active-low reset
//     evict_*             : evicted line from the victim cache (valid/ready)
//     lookup_addr/_hit/_data : combinational refill-path probe
//     mem_wr_req/_addr/_data/_ack : memory write channel, ack is a pulse
//     flush_req/flush_done   : level flush request, done when drained
//     wb_count            : number of occupied entries
// ---------------------------------------------------------------------------
module victim_wb_buffer
    import cache_defs::*;
#(
    parameter int WB_DEPTH   = VICTIM_WB_DEPTH,
    parameter int LINE_WIDTH = DCACHE_LINE_WIDTH,
    parameter int ADDR_WIDTH = LINE_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      evict_valid,
    input  logic                      evict_dirty,
    input  logic [ADDR_WIDTH-1:0]     evict_addr,
    input  logic [LINE_WIDTH-1:0]     evict_data,
    output logic                      evict_ready,
    input  logic [ADDR_WIDTH-1:0]     lookup_addr,
    output logic                      lookup_hit,
    output logic [LINE_WIDTH-1:0]     lookup_data,
    output logic                      mem_wr_req,
    output logic [ADDR_WIDTH-1:0]     mem_wr_addr,
    output logic [LINE_WIDTH-1:0]     mem_wr_data,
    input  logic                      mem_wr_ack,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic [$clog2(WB_DEPTH):0] wb_count
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    wb_state_t                           state_q, state_d;
    logic [PW-1:0]                       head_q, head_d;
    logic [PW-1:0]                       tail_q, tail_d;
    logic [CW-1:0]                       count_q, count_d;
    logic [WB_DEPTH-1:0]                 valid_q, valid_d;
    logic [WB_DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0]               data_q [WB_DEPTH];

    logic                full;
    logic                accept;
    logic                push;
    logic                pop;
    logic                coalesce;
    logic                coal_hit;
    logic [WB_DEPTH-1:0] head_lock;
    logic [WB_DEPTH-1:0] coal_valid;
    logic [WB_DEPTH-1:0] coal_yf;
    logic [WB_DEPTH-1:0] coal_phys;
    logic [WB_DEPTH-1:0] look_yf;
    logic [WB_DEPTH-1:0] look_phys;

    // ------------------------------------------------------------------
    // Handshake and classification of the incoming eviction
    // ------------------------------------------------------------------
    // Fullness uses the start-of-cycle count: a same-cycle pop never
    // frees a slot for the eviction presented in that cycle.
    assign full        = (count_q == CW'(WB_DEPTH));
    assign evict_ready = !full && !flush_req;
    assign accept      = evict_valid && evict_ready;

    // The head entry is being written to memory while in SEND; its data
    // must stay stable until ack, so it is hidden from coalescing.
    always_comb begin
        head_lock = '0;
        if (state_q == WB_SEND) begin
            head_lock[head_q] = 1'b1;
        end
    end
    assign coal_valid = valid_q & ~head_lock;

    wb_addr_match #(
        .DEPTH (WB_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_coal_match (
        .valid_i      (coal_valid),
        .addr_i       (addr_q),
        .probe_i      (evict_addr),
        .tail_i       (tail_q),
        .match_yf_o   (coal_yf),
        .match_phys_o (coal_phys)
    );

    assign coal_hit = |coal_yf;
    assign coalesce = accept && evict_dirty && coal_hit;
    assign push     = accept && evict_dirty && !coal_hit;
    assign pop      = (state_q == WB_SEND) && mem_wr_ack;

    // ------------------------------------------------------------------
    // Refill-path lookup (registered state only, so a line written this
    // cycle is not visible until the next one)
    // ------------------------------------------------------------------
    wb_addr_match #(
        .DEPTH (WB_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_look_match (
        .valid_i      (valid_q),
        .addr_i       (addr_q),
        .probe_i      (lookup_addr),
        .tail_i       (tail_q),
        .match_yf_o   (look_yf),
        .match_phys_o (look_phys)
    );

    assign lookup_hit = |look_yf;

    always_comb begin
        lookup_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (look_phys[i]) begin
                lookup_data = lookup_data | data_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM and queue bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: begin
                if (count_q != '0) begin
                    state_d = WB_SEND;
                end
            end
            WB_SEND: begin
                // Returning to IDLE on ack gives the one-cycle bubble.
                if (mem_wr_ack) begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WB_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: address and data are not reset; valid bits qualify
    // them. Data is written on a tail push or an in-place coalesce.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WB_DEPTH; gi++) begin : g_entry
            logic tail_sel;
            assign tail_sel = push && (tail_q == PW'(gi));

            always_ff @(posedge clk) begin
                if (tail_sel) begin
                    addr_q[gi] <= evict_addr;
                end
                if (tail_sel || (coalesce && coal_phys[gi])) begin
                    data_q[gi] <= evict_data;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_wr_req  = (state_q == WB_SEND);
    assign mem_wr_addr = addr_q[head_q];
    assign mem_wr_data = data_q[head_q];
    assign flush_done  = flush_req && (count_q == '0) && (state_q == WB_IDLE);
    assign wb_count    = count_q;

endmodule : victim_wb_buffer

// File: tb/tb_victim_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_victim_wb_buffer
//   Directed, table-driven bench for victim_wb_buffer plus hand-written
//   sequences for fill/backpressure, flush, and reset during a send.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_victim_wb_buffer;
    import cache_defs::*;

    localparam int AW = LINE_ADDR_WIDTH;
    localparam int LW = DCACHE_LINE_WIDTH;
    localparam int CW = $clog2(VICTIM_WB_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          evict_valid;
    logic          evict_dirty;
    logic [AW-1:0] evict_addr;
    logic [LW-1:0] evict_data;
    logic          evict_ready;
    logic [AW-1:0] lookup_addr;
    logic          lookup_hit;
    logic [LW-1:0] lookup_data;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [LW-1:0] mem_wr_data;
    logic          mem_wr_ack;
    logic          flush_req;
    logic          flush_done;
    logic [CW-1:0] wb_count;

    always #5 clk = ~clk;

    victim_wb_buffer #(
        .WB_DEPTH   (VICTIM_WB_DEPTH),
        .LINE_WIDTH (LW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .evict_valid (evict_valid),
        .evict_dirty (evict_dirty),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data),
        .evict_ready (evict_ready),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ack  (mem_wr_ack),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .wb_count    (wb_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          ev;
        logic          dty;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic          ack;
        logic [AW-1:0] laddr;
        logic          e_rdy;
        int            e_cnt;
        logic          e_req;
        logic [AW-1:0] e_waddr;
        logic [LW-1:0] e_wdata;
        logic          e_hit;
        logic [LW-1:0] e_ldata;
        logic          e_fdone;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    logic [LW-1:0] da5, db0, d1, d2, z;

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ev, input logic dty, input logic [AW-1:0] addr, input logic [LW-1:0] data,
        input logic ack, input logic [AW-1:0] laddr,
        input logic rdy, input int cnt, input logic req, input logic [AW-1:0] waddr,
        input logic [LW-1:0] wdata, input logic hit, input logic [LW-1:0] ldata, input logic fdone);
        vec_t v;
        v.ev = ev; v.dty = dty; v.addr = addr; v.data = data; v.ack = ack; v.laddr = laddr;
        v.e_rdy = rdy; v.e_cnt = cnt; v.e_req = req; v.e_waddr = waddr; v.e_wdata = wdata;
        v.e_hit = hit; v.e_ldata = ldata; v.e_fdone = fdone;
        return v;
    endfunction

    task automatic idle_inputs();
        evict_valid = 1'b0;
        evict_dirty = 1'b0;
        evict_addr  = '0;
        evict_data  = '0;
        mem_wr_ack  = 1'b0;
        flush_req   = 1'b0;
        lookup_addr = '0;
    endtask

    // Wait (bounded) until a write request is visible; an expired bound
    // shows up as a failed comparison.
    task automatic wait_req(input string nm);
        int n = 0;
        while (mem_wr_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, LW'(mem_wr_req), LW'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        da5 = {(LW/8){8'hA5}};
        db0 = {(LW/8){8'hB0}};
        d1  = {(LW/8){8'h11}};
        d2  = {(LW/8){8'h22}};
        z   = '0;

        //               ev    dty   addr    data ack   laddr  | rdy  cnt req   waddr   wdata hit   ldata fdone
        // single dirty line: request two cycles after push, ack in third request cycle
        tbl[0]  = mk(1'b1, 1'b1, 28'h10, da5, 1'b0, 28'h10, 1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h10, 1'b1, 1, 1'b0, 28'h0,  z,   1'b1, da5, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h10, 1'b1, 1, 1'b1, 28'h10, da5, 1'b1, da5, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h10, 1'b1, 1, 1'b1, 28'h10, da5, 1'b1, da5, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 28'h0,  z,   1'b1, 28'h10, 1'b1, 1, 1'b1, 28'h10, da5, 1'b1, da5, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h10, 1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);
        // clean line is dropped
        tbl[6]  = mk(1'b1, 1'b0, 28'h20, db0, 1'b0, 28'h20, 1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h20, 1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h20, 1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);
        // coalesce into a pending (not in-flight) entry
        tbl[9]  = mk(1'b1, 1'b1, 28'h5,  d1,  1'b0, 28'h5,  1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);
        tbl[10] = mk(1'b1, 1'b1, 28'h5,  d2,  1'b0, 28'h5,  1'b1, 1, 1'b0, 28'h0,  z,   1'b1, d1,  1'b0);
        tbl[11] = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h5,  1'b1, 1, 1'b1, 28'h5,  d2,  1'b1, d2,  1'b0);
        tbl[12] = mk(1'b0, 1'b0, 28'h0,  z,   1'b1, 28'h5,  1'b1, 1, 1'b1, 28'h5,  d2,  1'b1, d2,  1'b0);
        tbl[13] = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h5,  1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);
        // same line while head is in flight: appended, head stays stable, youngest wins lookup
        tbl[14] = mk(1'b1, 1'b1, 28'h6,  d1,  1'b0, 28'h6,  1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);
        tbl[15] = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h6,  1'b1, 1, 1'b0, 28'h0,  z,   1'b1, d1,  1'b0);
        tbl[16] = mk(1'b1, 1'b1, 28'h6,  d2,  1'b0, 28'h6,  1'b1, 1, 1'b1, 28'h6,  d1,  1'b1, d1,  1'b0);
        tbl[17] = mk(1'b0, 1'b0, 28'h0,  z,   1'b1, 28'h6,  1'b1, 2, 1'b1, 28'h6,  d1,  1'b1, d2,  1'b0);
        tbl[18] = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h6,  1'b1, 1, 1'b0, 28'h0,  z,   1'b1, d2,  1'b0);
        tbl[19] = mk(1'b0, 1'b0, 28'h0,  z,   1'b1, 28'h6,  1'b1, 1, 1'b1, 28'h6,  d2,  1'b1, d2,  1'b0);
        tbl[20] = mk(1'b0, 1'b0, 28'h0,  z,   1'b0, 28'h6,  1'b1, 0, 1'b0, 28'h0,  z,   1'b0, z,   1'b0);

        // ---------------- reset with ack toggling ----------------
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_wr_ack = ~mem_wr_ack;
        end
        #1;
        chk("rst_req",   LW'(mem_wr_req),  LW'(1'b0));
        chk("rst_count", LW'(wb_count),    LW'(0));
        chk("rst_ready", LW'(evict_ready), LW'(1'b1));
        chk("rst_hit",   LW'(lookup_hit),  LW'(1'b0));
        chk("rst_fdone", LW'(flush_done),  LW'(1'b0));
        $display("reset: req=%0b count=%0d ready=%0b hit=%0b", mem_wr_req, wb_count, evict_ready, lookup_hit);
        @(negedge clk);
        rst = 1'b1;
        mem_wr_ack = 1'b0;
        @(negedge clk);
        flush_req = 1'b1;
        #1;
        chk("idle_flush_done",  LW'(flush_done),  LW'(1'b1));
        chk("idle_flush_ready", LW'(evict_ready), LW'(1'b0));
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        chk("post_rst_req", LW'(mem_wr_req), LW'(1'b0));

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            evict_valid = tbl[i].ev;
            evict_dirty = tbl[i].dty;
            evict_addr  = tbl[i].addr;
            evict_data  = tbl[i].data;
            mem_wr_ack  = tbl[i].ack;
            lookup_addr = tbl[i].laddr;
            flush_req   = 1'b0;
            #1;
            $display("vec %0d: ready=%0b count=%0d req=%0b waddr=%h hit=%0b", i,
                     evict_ready, wb_count, mem_wr_req, mem_wr_addr, lookup_hit);
            chk($sformatf("v%0d_ready", i), LW'(evict_ready), LW'(tbl[i].e_rdy));
            chk($sformatf("v%0d_count", i), LW'(wb_count),    LW'(tbl[i].e_cnt));
            chk($sformatf("v%0d_req", i),   LW'(mem_wr_req),  LW'(tbl[i].e_req));
            chk($sformatf("v%0d_hit", i),   LW'(lookup_hit),  LW'(tbl[i].e_hit));
            chk($sformatf("v%0d_ldata", i), lookup_data,      tbl[i].e_ldata);
            chk($sformatf("v%0d_fdone", i), LW'(flush_done),  LW'(tbl[i].e_fdone));
            if (tbl[i].e_req) begin
                chk($sformatf("v%0d_waddr", i), LW'(mem_wr_addr), LW'(tbl[i].e_waddr));
                chk($sformatf("v%0d_wdata", i), mem_wr_data,      tbl[i].e_wdata);
            end
        end
        idle_inputs();

        // ---------------- fill to full, backpressure, drain order ----------------
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            evict_valid = 1'b1;
            evict_dirty = 1'b1;
            evict_addr  = AW'(i);
            evict_data  = {(LW/8){i[7:0]}};
            #1;
            $display("fill push addr=%0h ready=%0b count=%0d", evict_addr, evict_ready, wb_count);
            chk($sformatf("fill%0d_ready", i), LW'(evict_ready), LW'(1'b1));
        end
        @(negedge clk);
        evict_addr = AW'(5);
        evict_data = {(LW/8){8'h55}};
        #1;
        chk("full_ready", LW'(evict_ready), LW'(1'b0));
        chk("full_count", LW'(wb_count),    LW'(4));
        @(negedge clk);
        #1;
        chk("fifth_rejected_count", LW'(wb_count),    LW'(4));
        chk("full_head_addr",       LW'(mem_wr_addr), LW'(28'h1));
        chk("full_req",             LW'(mem_wr_req),  LW'(1'b1));
        @(negedge clk);
        mem_wr_ack = 1'b1;
        #1;
        $display("drain ack addr=%0h", mem_wr_addr);
        chk("pop_full_ready", LW'(evict_ready), LW'(1'b0));
        chk("drain1_addr",    LW'(mem_wr_addr), LW'(28'h1));
        @(negedge clk);
        mem_wr_ack  = 1'b0;
        evict_valid = 1'b0;
        #1;
        chk("after_pop_ready", LW'(evict_ready), LW'(1'b1));
        chk("after_pop_count", LW'(wb_count),    LW'(3));
        chk("bubble_req",      LW'(mem_wr_req),  LW'(1'b0));
        for (int k = 2; k <= 4; k++) begin
            wait_req($sformatf("drain%0d_req", k));
            $display("drain ack addr=%0h", mem_wr_addr);
            chk($sformatf("drain%0d_addr", k), LW'(mem_wr_addr), LW'(k));
            chk($sformatf("drain%0d_data", k), mem_wr_data,      {(LW/8){k[7:0]}});
            @(negedge clk);
            mem_wr_ack = 1'b1;
            @(negedge clk);
            mem_wr_ack = 1'b0;
            #1;
        end
        chk("drained_count", LW'(wb_count), LW'(0));
        idle_inputs();

        // ---------------- flush ----------------
        @(negedge clk);
        evict_valid = 1'b1;
        evict_dirty = 1'b1;
        evict_addr  = 28'h7;
        evict_data  = d1;
        #1;
        chk("flush_push_ready", LW'(evict_ready), LW'(1'b1));
        @(negedge clk);
        flush_req  = 1'b1;
        evict_addr = 28'h8;
        evict_data = d2;
        #1;
        chk("flush_ready",       LW'(evict_ready), LW'(1'b0));
        chk("flush_done_early",  LW'(flush_done),  LW'(1'b0));
        chk("flush_count",       LW'(wb_count),    LW'(1));
        wait_req("flush_req_seen");
        chk("flush_no_accept",   LW'(wb_count),    LW'(1));
        chk("flush_done_send",   LW'(flush_done),  LW'(1'b0));
        @(negedge clk);
        mem_wr_ack = 1'b1;
        #1;
        chk("flush_done_at_ack", LW'(flush_done),  LW'(1'b0));
        @(negedge clk);
        mem_wr_ack = 1'b0;
        #1;
        $display("flush: count=%0d done=%0b", wb_count, flush_done);
        chk("flush_empty",       LW'(wb_count),    LW'(0));
        chk("flush_done",        LW'(flush_done),  LW'(1'b1));
        @(negedge clk);
        flush_req   = 1'b0;
        evict_valid = 1'b0;
        #1;
        chk("flush_release_done",  LW'(flush_done),  LW'(1'b0));
        chk("flush_release_ready", LW'(evict_ready), LW'(1'b1));

        // ---------------- reset during SEND ----------------
        @(negedge clk);
        evict_valid = 1'b1;
        evict_dirty = 1'b1;
        evict_addr  = 28'h9;
        evict_data  = da5;
        @(negedge clk);
        evict_valid = 1'b0;
        lookup_addr = 28'h9;
        #1;
        wait_req("rstsend_req_seen");
        #2;
        rst = 1'b0;
        #1;
        $display("reset in send: req=%0b count=%0d", mem_wr_req, wb_count);
        chk("rstsend_req",   LW'(mem_wr_req), LW'(1'b0));
        chk("rstsend_count", LW'(wb_count),   LW'(0));
        chk("rstsend_hit",   LW'(lookup_hit), LW'(1'b0));
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rstsend_after_req", LW'(mem_wr_req), LW'(1'b0));
        chk("rstsend_after_hit", LW'(lookup_hit), LW'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_victim_wb_buffer
